// File: rtl/codec_i2c_sequencer.sv
// SSM2603 codec I2C sequencer: runs the power-up init table, then serves single
// register host writes/reads and returns results with level-held handshakes.
module codec_i2c_sequencer #(
   parameter int         POWERUP_CYCLES = 1000,
   parameter int         MAX_RETRIES    = 3,
   parameter logic [6:0] CODEC_DEV_ADDR = 7'h1A
) (
   input  logic        board_clk,
   input  logic        reset,
   input  logic        codec_i2c_data_wr,
   input  logic        codec_i2c_data_rd,
   input  logic [31:0] codec_i2c_addr,
   input  logic [31:0] codec_i2c_wr_data,
   output logic        clear_codec_i2c_data_wr,
   output logic        clear_codec_i2c_data_rd,
   output logic        controller_busy,
   output logic        codec_init_done,
   output logic [31:0] codec_i2c_rd_data,
   output logic        update_codec_i2c_rd_data,
   output logic        init_error,
   output logic        i2c_cmd_valid,
   input  logic        i2c_cmd_ready,
   output logic        i2c_cmd_rnw,
   output logic [6:0]  i2c_cmd_dev,
   output logic [15:0] i2c_cmd_word,
   input  logic        i2c_rsp_valid,
   input  logic        i2c_rsp_nack,
   input  logic [8:0]  i2c_rsp_data,
   output logic [2:0]  fsm_state
);

   localparam logic [2:0] ST_PWRUP      = 3'd0;
   localparam logic [2:0] ST_INIT_ISSUE = 3'd1;
   localparam logic [2:0] ST_INIT_WAIT  = 3'd2;
   localparam logic [2:0] ST_IDLE       = 3'd3;
   localparam logic [2:0] ST_HOST_ISSUE = 3'd4;
   localparam logic [2:0] ST_HOST_WAIT  = 3'd5;
   localparam logic [2:0] ST_HOST_ACK   = 3'd6;

   localparam int INIT_LEN = 11;
   localparam int PW_W     = (POWERUP_CYCLES > 1) ? $clog2(POWERUP_CYCLES) : 1;
   localparam int RT_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

   logic [2:0]      state;
   logic [PW_W-1:0] pwr_cnt;
   logic [3:0]      idx;
   logic [RT_W-1:0] retries;
   logic            host_rd;
   logic [15:0]     host_word;
   logic            retry_now;
   logic            host_release;
   logic            unused_bits;

   // Codec init table, {reg[6:0], data[8:0]}, issued in index order.
   function automatic logic [15:0] init_word(input logic [3:0] i);
      case (i)
         4'd0:    init_word = {7'h0F, 9'h000};
         4'd1:    init_word = {7'h06, 9'h030};
         4'd2:    init_word = {7'h00, 9'h017};
         4'd3:    init_word = {7'h01, 9'h017};
         4'd4:    init_word = {7'h02, 9'h079};
         4'd5:    init_word = {7'h03, 9'h079};
         4'd6:    init_word = {7'h04, 9'h010};
         4'd7:    init_word = {7'h05, 9'h000};
         4'd8:    init_word = {7'h07, 9'h00A};
         4'd9:    init_word = {7'h08, 9'h000};
         4'd10:   init_word = {7'h09, 9'h001};
         default: init_word = 16'h0000;
      endcase
   endfunction

   // Command: all fields are held stable while i2c_cmd_valid is high and the
   // transfer happens in the cycle valid && ready. Response: i2c_rsp_valid is a
   // one-cycle pulse qualifying nack/data, honoured only in the WAIT states.
   assign i2c_cmd_valid   = (state == ST_INIT_ISSUE) || (state == ST_HOST_ISSUE);
   assign i2c_cmd_rnw     = (state == ST_HOST_ISSUE) && host_rd;
   assign i2c_cmd_dev     = CODEC_DEV_ADDR;
   assign controller_busy = (state != ST_IDLE);
   assign fsm_state       = state;
   assign retry_now       = i2c_rsp_nack && (retries < RT_W'(MAX_RETRIES));
   assign host_release    = host_rd ? !codec_i2c_data_rd : !codec_i2c_data_wr;
   assign unused_bits     = ^{codec_i2c_addr[31:7], codec_i2c_wr_data[31:9]};

   always_comb begin
      i2c_cmd_word = 16'h0000;
      if (state == ST_INIT_ISSUE)
         i2c_cmd_word = init_word(idx);
      else if (state == ST_HOST_ISSUE)
         i2c_cmd_word = host_word;
   end

   always_ff @(posedge board_clk) begin
      if (reset) begin
         state                    <= ST_PWRUP;
         pwr_cnt                  <= '0;
         idx                      <= '0;
         retries                  <= '0;
         host_rd                  <= 1'b0;
         host_word                <= '0;
         clear_codec_i2c_data_wr  <= 1'b0;
         clear_codec_i2c_data_rd  <= 1'b0;
         update_codec_i2c_rd_data <= 1'b0;
         codec_i2c_rd_data        <= '0;
         codec_init_done          <= 1'b0;
         init_error               <= 1'b0;
      end else begin
         case (state)
            ST_PWRUP: begin
               if (pwr_cnt == PW_W'(POWERUP_CYCLES - 1)) begin
                  state <= ST_INIT_ISSUE;
                  idx   <= '0;
               end else begin
                  pwr_cnt <= pwr_cnt + 1'b1;
               end
            end
            ST_INIT_ISSUE: if (i2c_cmd_ready) state <= ST_INIT_WAIT;
            ST_INIT_WAIT: begin
               if (i2c_rsp_valid) begin
                  if (retry_now) begin
                     retries <= retries + 1'b1;
                     state   <= ST_INIT_ISSUE;
                  end else begin
                     // Exhausted retries skip the entry; the table still completes.
                     retries <= '0;
                     if (i2c_rsp_nack) init_error <= 1'b1;
                     if (idx == 4'(INIT_LEN - 1)) begin
                        codec_init_done <= 1'b1;
                        state           <= ST_IDLE;
                     end else begin
                        idx   <= idx + 1'b1;
                        state <= ST_INIT_ISSUE;
                     end
                  end
               end
            end
            ST_IDLE: begin
               if (codec_i2c_data_wr && !clear_codec_i2c_data_wr) begin
                  host_rd   <= 1'b0;
                  host_word <= {codec_i2c_addr[6:0], codec_i2c_wr_data[8:0]};
                  state     <= ST_HOST_ISSUE;
               end else if (codec_i2c_data_rd && !clear_codec_i2c_data_rd) begin
                  host_rd   <= 1'b1;
                  host_word <= {codec_i2c_addr[6:0], 9'd0};
                  state     <= ST_HOST_ISSUE;
               end
            end
            ST_HOST_ISSUE: if (i2c_cmd_ready) state <= ST_HOST_WAIT;
            ST_HOST_WAIT: begin
               if (i2c_rsp_valid) begin
                  if (retry_now) begin
                     retries <= retries + 1'b1;
                     state   <= ST_HOST_ISSUE;
                  end else begin
                     retries <= '0;
                     state   <= ST_HOST_ACK;
                     if (host_rd) begin
                        codec_i2c_rd_data        <= {i2c_rsp_nack, 22'd0,
                                                     i2c_rsp_nack ? 9'd0 : i2c_rsp_data};
                        update_codec_i2c_rd_data <= 1'b1;
                        clear_codec_i2c_data_rd  <= 1'b1;
                     end else begin
                        clear_codec_i2c_data_wr  <= 1'b1;
                     end
                  end
               end
            end
            ST_HOST_ACK: begin
               if (host_release) begin
                  clear_codec_i2c_data_wr  <= 1'b0;
                  clear_codec_i2c_data_rd  <= 1'b0;
                  update_codec_i2c_rd_data <= 1'b0;
                  state                    <= ST_IDLE;
               end
            end
            default: state <= ST_PWRUP;
         endcase
      end
   end

endmodule

// File: tb/tb_codec_i2c_sequencer.sv
// Bench for codec_i2c_sequencer: a randomized I2C engine/codec model plus
// per-scenario tasks checked against expectations derived from the codec rules.
module tb_codec_i2c_sequencer;

   localparam int         PC    = 8;
   localparam int         MAX_R = 3;
   localparam logic [6:0] DEV   = 7'h1A;

   logic        board_clk = 1'b0;
   logic        reset = 1'b1;
   logic        wr = 1'b0, rd = 1'b0;
   logic [31:0] addr = '0, wdata = '0;
   logic        clear_wr, clear_rd, busy, init_done, update, init_error;
   logic [31:0] rd_data;
   logic        cmd_valid, cmd_ready, cmd_rnw;
   logic [6:0]  cmd_dev;
   logic [15:0] cmd_word;
   logic        rsp_valid, rsp_nack;
   logic [8:0]  rsp_data;
   logic [2:0]  fsm_state;

   int n_vec = 0;
   int n_err = 0;
   int stab_err = 0;
   logic [15:0] got_word[$];
   logic        got_rnw[$];
   logic [6:0]  got_dev[$];
   bit          nack_plan[$];
   bit          suppress_rsp = 1'b0;
   bit          late_rsp_req = 1'b0;
   logic [8:0]  codec_mem [128];
   logic [8:0]  ref_regs [128];
   logic [6:0]  init_reg [11] = '{7'h0F, 7'h06, 7'h00, 7'h01, 7'h02, 7'h03,
                                  7'h04, 7'h05, 7'h07, 7'h08, 7'h09};
   logic [8:0]  init_dat [11] = '{9'h000, 9'h030, 9'h017, 9'h017, 9'h079, 9'h079,
                                  9'h010, 9'h000, 9'h00A, 9'h000, 9'h001};

   codec_i2c_sequencer #(.POWERUP_CYCLES(PC), .MAX_RETRIES(MAX_R), .CODEC_DEV_ADDR(DEV)) dut (
      .board_clk(board_clk), .reset(reset),
      .codec_i2c_data_wr(wr), .codec_i2c_data_rd(rd),
      .codec_i2c_addr(addr), .codec_i2c_wr_data(wdata),
      .clear_codec_i2c_data_wr(clear_wr), .clear_codec_i2c_data_rd(clear_rd),
      .controller_busy(busy), .codec_init_done(init_done),
      .codec_i2c_rd_data(rd_data), .update_codec_i2c_rd_data(update),
      .init_error(init_error),
      .i2c_cmd_valid(cmd_valid), .i2c_cmd_ready(cmd_ready), .i2c_cmd_rnw(cmd_rnw),
      .i2c_cmd_dev(cmd_dev), .i2c_cmd_word(cmd_word),
      .i2c_rsp_valid(rsp_valid), .i2c_rsp_nack(rsp_nack), .i2c_rsp_data(rsp_data),
      .fsm_state(fsm_state)
   );

   // ---------------- clock / reset ----------------
   always #5 board_clk = ~board_clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Leaves reset high at a falling edge with the capture queues emptied.
   task automatic apply_reset();
      @(negedge board_clk);
      reset = 1'b1;
      repeat (3) @(negedge board_clk);
      got_word.delete(); got_rnw.delete(); got_dev.delete(); nack_plan.delete();
   endtask

   // ---------------- engine / codec model ----------------
   initial begin
      int phase, wait_n, dly;
      logic [15:0] snap_w;
      logic        snap_r;
      phase = 0; wait_n = 0; dly = 0; snap_w = '0; snap_r = 1'b0;
      for (int i = 0; i < 128; i++) begin codec_mem[i] = '0; ref_regs[i] = '0; end
      cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = '0;
      forever begin
         @(negedge board_clk);
         cmd_ready = 1'b0; rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = '0;
         if (reset) begin
            phase = 0;
         end else begin
            if (late_rsp_req) begin
               rsp_valid = 1'b1; rsp_data = 9'h1AB; late_rsp_req = 1'b0;
            end
            if (phase == 0 && !cmd_valid) begin
               cmd_ready = ($urandom_range(0, 3) == 0);
               if (!suppress_rsp && !rsp_valid && $urandom_range(0, 7) == 0) begin
                  rsp_valid = 1'b1; rsp_data = 9'($urandom);
               end
            end
            if (phase == 0 && cmd_valid) begin
               snap_w = cmd_word; snap_r = cmd_rnw;
               wait_n = $urandom_range(0, 2); phase = 1;
            end
            if (phase == 1) begin
               if (cmd_valid !== 1'b1 || cmd_word !== snap_w || cmd_rnw !== snap_r) stab_err++;
               if (wait_n == 0) begin
                  cmd_ready = 1'b1;
                  got_word.push_back(cmd_word); got_rnw.push_back(cmd_rnw); got_dev.push_back(cmd_dev);
                  dly = $urandom_range(0, 3); phase = 2;
               end else begin
                  wait_n--;
               end
            end else if (phase == 2) begin
               if (dly == 0) begin
                  if (!suppress_rsp) begin
                     rsp_valid = 1'b1;
                     rsp_nack  = (nack_plan.size() > 0) ? nack_plan.pop_front() : 1'b0;
                     if (snap_r)
                        rsp_data = rsp_nack ? 9'($urandom_range(1, 511)) : codec_mem[snap_w[15:9]];
                     else if (!rsp_nack)
                        codec_mem[snap_w[15:9]] = snap_w[8:0];
                  end
                  phase = 0;
               end else begin
                  dly--;
               end
            end
         end
      end
   end

   // ---------------- driver helpers ----------------
   // sel: 0 init_done, 1 clear_wr, 2 clear_rd. Scramble host buses once a command is out.
   task automatic wait_for(input int sel, input int budget, input bit scramble, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < budget; c++) begin
         @(negedge board_clk);
         if (scramble && cmd_valid) begin addr = $urandom; wdata = $urandom; end
         case (sel)
            0: ok = init_done;
            1: ok = clear_wr;
            default: ok = clear_rd;
         endcase
         if (ok) break;
      end
   endtask

   function automatic int attempts(input int nacks);
      return (nacks > MAX_R) ? MAX_R + 1 : nacks + 1;
   endfunction

   // ---------------- scenarios ----------------
   task automatic test_reset();
      int cnt;
      bit busy_low;
      apply_reset();
      n_vec++;
      if ({cmd_valid, cmd_rnw, busy, init_done, init_error, clear_wr, clear_rd, update} !== 8'b0010_0000) begin
         n_err++;
         $display("FAIL reset_flags: got %b expected 00100000",
                  {cmd_valid, cmd_rnw, busy, init_done, init_error, clear_wr, clear_rd, update});
      end
      n_vec++;
      if (cmd_word !== 16'h0000) begin n_err++; $display("FAIL reset_word: got %h expected 0000", cmd_word); end
      n_vec++;
      if (cmd_dev !== DEV) begin n_err++; $display("FAIL reset_dev: got %h expected %h", cmd_dev, DEV); end
      n_vec++;
      if (rd_data !== 32'h0) begin n_err++; $display("FAIL reset_rd_data: got %h expected 0", rd_data); end
      reset = 1'b0;
      cnt = 0; busy_low = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge board_clk);
         cnt++;
         if (!busy) busy_low = 1'b1;
         if (cmd_valid) break;
      end
      n_vec++;
      if (cnt != PC) begin n_err++; $display("FAIL powerup_delay: got %0d cycles expected %0d", cnt, PC); end
      n_vec++;
      if (busy_low) begin n_err++; $display("FAIL powerup_busy: got busy low expected high"); end
   endtask

   task automatic test_init(input string name, input int bad_idx, input int bad_n, input bit rand_plan);
      int n [11];
      logic [15:0] exp_q[$];
      bit exp_err, ok;
      exp_err = 1'b0;
      apply_reset();
      for (int i = 0; i < 11; i++) begin
         n[i] = rand_plan ? (($urandom_range(0, 5) == 0) ? 4 : int'($urandom_range(0, 2))) : 0;
         if (i == bad_idx) n[i] = bad_n;
         for (int a = 0; a < attempts(n[i]); a++) begin
            exp_q.push_back({init_reg[i], init_dat[i]});
            nack_plan.push_back(a < n[i]);
         end
         if (n[i] > MAX_R) exp_err = 1'b1;
         else ref_regs[init_reg[i]] = init_dat[i];
      end
      reset = 1'b0;
      wait_for(0, 3000, 1'b0, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL %s_done: got init_done 0 expected 1", name); end
      n_vec++;
      if (got_word.size() != exp_q.size()) begin
         n_err++; $display("FAIL %s_count: got %0d commands expected %0d", name, got_word.size(), exp_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < got_word.size(); i++) begin
         n_vec++;
         if (got_word[i] !== exp_q[i] || got_rnw[i] !== 1'b0 || got_dev[i] !== DEV) begin
            n_err++;
            $display("FAIL %s_cmd[%0d]: got word %h rnw %b dev %h expected word %h rnw 0 dev %h",
                     name, i, got_word[i], got_rnw[i], got_dev[i], exp_q[i], DEV);
         end
      end
      n_vec++;
      if (init_error !== exp_err) begin n_err++; $display("FAIL %s_error: got %b expected %b", name, init_error, exp_err); end
      @(negedge board_clk);
      n_vec++;
      if ({busy, cmd_valid} !== 2'b00) begin n_err++; $display("FAIL %s_idle: got busy,valid %b expected 00", name, {busy, cmd_valid}); end
   endtask

   task automatic test_host_write(input logic [6:0] a, input logic [8:0] d, input int nacks);
      int base, att;
      bit ok;
      att = attempts(nacks);
      for (int k = 0; k < att; k++) nack_plan.push_back(k < nacks);
      base = got_word.size();
      addr = $urandom; addr[6:0] = a; wdata = $urandom; wdata[8:0] = d;
      wr = 1'b1;
      wait_for(1, 500, 1'b1, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL wr_ack: got clear_wr 0 expected 1 (addr %h)", a); end
      n_vec++;
      if (got_word.size() - base != att) begin
         n_err++; $display("FAIL wr_attempts: got %0d expected %0d", got_word.size() - base, att);
      end
      for (int k = base; k < got_word.size(); k++) begin
         n_vec++;
         if (got_word[k] !== {a, d} || got_rnw[k] !== 1'b0) begin
            n_err++; $display("FAIL wr_cmd: got word %h rnw %b expected word %h rnw 0", got_word[k], got_rnw[k], {a, d});
         end
      end
      n_vec++;
      if ({clear_rd, update} !== 2'b00) begin n_err++; $display("FAIL wr_side: got clear_rd,update %b expected 00", {clear_rd, update}); end
      repeat ($urandom_range(1, 4)) @(negedge board_clk);
      n_vec++;
      if ({clear_wr, busy} !== 2'b11 || got_word.size() - base != att) begin
         n_err++; $display("FAIL wr_hold: got clear_wr,busy %b cmds %0d expected 11 cmds %0d",
                           {clear_wr, busy}, got_word.size() - base, att);
      end
      wr = 1'b0;
      @(negedge board_clk);
      n_vec++;
      if ({clear_wr, busy} !== 2'b00) begin n_err++; $display("FAIL wr_release: got clear_wr,busy %b expected 00", {clear_wr, busy}); end
      if (nacks <= MAX_R) ref_regs[a] = d;
   endtask

   task automatic test_host_read(input logic [6:0] a, input int nacks);
      int base, att;
      bit ok;
      logic [31:0] exp;
      att = attempts(nacks);
      exp = (nacks > MAX_R) ? 32'h8000_0000 : {23'd0, ref_regs[a]};
      for (int k = 0; k < att; k++) nack_plan.push_back(k < nacks);
      base = got_word.size();
      addr = $urandom; addr[6:0] = a; wdata = $urandom;
      rd = 1'b1;
      wait_for(2, 500, 1'b1, ok);
      n_vec++;
      if (!ok) begin n_err++; $display("FAIL rd_ack: got clear_rd 0 expected 1 (addr %h)", a); end
      n_vec++;
      if (got_word.size() - base != att) begin
         n_err++; $display("FAIL rd_attempts: got %0d expected %0d", got_word.size() - base, att);
      end
      for (int k = base; k < got_word.size(); k++) begin
         n_vec++;
         if (got_word[k] !== {a, 9'd0} || got_rnw[k] !== 1'b1) begin
            n_err++; $display("FAIL rd_cmd: got word %h rnw %b expected word %h rnw 1", got_word[k], got_rnw[k], {a, 9'd0});
         end
      end
      n_vec++;
      if (rd_data !== exp || {update, clear_wr} !== 2'b10) begin
         n_err++; $display("FAIL rd_data: got %h upd,clr_wr %b expected %h 10", rd_data, {update, clear_wr}, exp);
      end
      repeat ($urandom_range(1, 4)) @(negedge board_clk);
      n_vec++;
      if (rd_data !== exp || {update, clear_rd, busy} !== 3'b111) begin
         n_err++; $display("FAIL rd_hold: got %h upd,clr,busy %b expected %h 111", rd_data, {update, clear_rd, busy}, exp);
      end
      rd = 1'b0;
      @(negedge board_clk);
      n_vec++;
      if ({update, clear_rd, busy} !== 3'b000) begin
         n_err++; $display("FAIL rd_release: got upd,clr,busy %b expected 000", {update, clear_rd, busy});
      end
   endtask

   task automatic test_host_random();
      logic [6:0] a;
      for (int t = 0; t < 8; t++) begin
         a = 7'($urandom_range(0, 127));
         test_host_write(a, 9'($urandom), ($urandom_range(0, 3) == 0) ? 4 : int'($urandom_range(0, 2)));
         test_host_read(a, ($urandom_range(0, 3) == 0) ? 4 : int'($urandom_range(0, 2)));
      end
   endtask

   task automatic test_wr_rd_priority();
      logic [6:0] a;
      logic [8:0] d;
      bit ok;
      a = 7'($urandom_range(16, 127)); d = 9'($urandom);
      apply_reset();
      for (int i = 0; i < 11; i++) ref_regs[init_reg[i]] = init_dat[i];
      addr = $urandom; addr[6:0] = a; wdata = $urandom; wdata[8:0] = d;
      wr = 1'b1; rd = 1'b1;
      reset = 1'b0;
      wait_for(0, 3000, 1'b0, ok);
      n_vec++;
      if (!ok || got_word.size() != 11 || {clear_wr, clear_rd} !== 2'b00) begin
         n_err++; $display("FAIL prio_init: got done %b cmds %0d clr %b expected 1 11 00", ok, got_word.size(), {clear_wr, clear_rd});
      end
      wait_for(1, 500, 1'b0, ok);
      n_vec++;
      if (!ok || got_word.size() != 12 || got_word[got_word.size()-1] !== {a, d} || got_rnw[got_rnw.size()-1] !== 1'b0) begin
         n_err++; $display("FAIL prio_write_first: got done %b cmds %0d last %h expected 1 12 %h", ok, got_word.size(),
                           got_word[got_word.size()-1], {a, d});
      end
      repeat ($urandom_range(2, 5)) @(negedge board_clk);
      n_vec++;
      if (got_word.size() != 12 || clear_rd !== 1'b0) begin
         n_err++; $display("FAIL prio_read_waits: got cmds %0d clear_rd %b expected 12 0", got_word.size(), clear_rd);
      end
      wr = 1'b0;
      wait_for(2, 500, 1'b0, ok);
      n_vec++;
      if (!ok || got_word.size() != 13 || got_word[got_word.size()-1] !== {a, 9'd0} || rd_data !== {23'd0, d}) begin
         n_err++; $display("FAIL prio_read: got done %b cmds %0d last %h data %h expected 1 13 %h %h", ok, got_word.size(),
                           got_word[got_word.size()-1], rd_data, {a, 9'd0}, {23'd0, d});
      end
      rd = 1'b0;
      @(negedge board_clk);
      ref_regs[a] = d;
   endtask

   task automatic test_reset_midflight();
      int base, cnt;
      bit seen, ok;
      suppress_rsp = 1'b1;
      base = got_word.size();
      addr = 32'h0000_0007; rd = 1'b1;
      for (int c = 0; c < 100 && got_word.size() == base; c++) @(negedge board_clk);
      repeat (2) @(negedge board_clk);
      n_vec++;
      if (got_word.size() != base + 1 || {busy, update} !== 2'b10) begin
         n_err++; $display("FAIL mid_pending: got cmds %0d busy,upd %b expected %0d 10", got_word.size(), {busy, update}, base + 1);
      end
      reset = 1'b1;
      @(negedge board_clk);
      n_vec++;
      if ({cmd_valid, busy, init_done, init_error, clear_wr, clear_rd, update} !== 7'b0100000 || rd_data !== 32'h0) begin
         n_err++; $display("FAIL mid_reset: got %b data %h expected 0100000 data 0",
                           {cmd_valid, busy, init_done, init_error, clear_wr, clear_rd, update}, rd_data);
      end
      got_word.delete(); got_rnw.delete(); got_dev.delete(); nack_plan.delete();
      rd = 1'b0;
      reset = 1'b0; suppress_rsp = 1'b0; late_rsp_req = 1'b1;
      cnt = 0; seen = 1'b0;
      for (int c = 0; c < 100; c++) begin
         @(negedge board_clk);
         cnt++;
         if (update || clear_rd || !busy) seen = 1'b1;
         if (cmd_valid) break;
      end
      n_vec++;
      if (cnt != PC || seen) begin n_err++; $display("FAIL mid_restart: got %0d cycles late-effect %b expected %0d 0", cnt, seen, PC); end
      wait_for(0, 3000, 1'b0, ok);
      n_vec++;
      if (!ok || got_word.size() != 11 || got_word[0] !== 16'h1E00) begin
         n_err++; $display("FAIL mid_reinit: got done %b cmds %0d first %h expected 1 11 1e00", ok, got_word.size(), got_word[0]);
      end
   endtask

   task automatic test_handshake_stability();
      n_vec++;
      if (stab_err != 0) begin n_err++; $display("FAIL cmd_stable: got %0d violations expected 0", stab_err); end
   endtask

   // ---------------- sequence / report ----------------
   initial begin
      test_reset();
      test_init("init_clean", -1, 0, 1'b0);
      test_host_write(7'h04, 9'h012, 0);
      test_host_read(7'h07, 0);
      test_host_random();
      test_host_write(7'h11, 9'h155, 4);
      test_host_read(7'h11, 4);
      test_host_read(7'h04, 2);
      test_init("init_nack", 2, 4, 1'b0);
      test_init("init_rand", -1, 0, 1'b1);
      test_host_read(7'h00, 1);
      test_wr_rd_priority();
      test_reset_midflight();
      test_handshake_stability();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
